race_sequencer: RTL

- Parametrised N-player race sequencer. It replaces the ad-hoc status wiring between the light-signal timer, per-player timers, controller enables and finish detection.
- Sits between game_menu/scoreboard and the per-player game_controller instances, all in the clk65MHz domain.
- Runs countdown lights, per-player millisecond race timers and finish detection.
- Adds behaviour the current wiring lacks: false-start disqualification and winner/tie resolution.

---
 rtl/race_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/race_sequencer.sv
// Race sequencer: countdown lights, per-player ms timers, finish detection,
// false-start disqualification and winner/tie resolution.
module race_sequencer #(
  parameter int NUM_PLAYERS     = 2,
  parameter int POS_WIDTH       = 32,
  parameter int FINISH_LINE_POS = 1200,
  parameter int TICK_DIV        = 65000,
  parameter int COUNTDOWN_SEC   = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_game,
  input  logic                           restart,
  input  logic [NUM_PLAYERS-1:0]         throttle,
  input  logic [NUM_PLAYERS*POS_WIDTH-1:0] position,
  output logic [1:0]                     state,
  output logic [2:0]                     light_count,
  output logic                           race_active,
  output logic [NUM_PLAYERS-1:0]         enable,
  output logic [NUM_PLAYERS-1:0]         finished,
  output logic [NUM_PLAYERS-1:0]         false_start,
  output logic [NUM_PLAYERS*22-1:0]      race_time,
  output logic [2:0]                     winner,
  output logic                           winner_valid,
  output logic                           tie
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_END = DIV_W'(TICK_DIV - 1);
  localparam logic [POS_WIDTH-1:0] FINISH = POS_WIDTH'(FINISH_LINE_POS);
  localparam logic [2:0] LIGHT_END = 3'(COUNTDOWN_SEC);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    RACE      = 2'd2,
    DONE      = 2'd3
  } state_e;

  state_e                        state_q, state_d;
  logic [DIV_W-1:0]              div_q, div_d;
  logic [9:0]                    cd_ms_q, cd_ms_d;
  logic [2:0]                    light_q, light_d;
  logic [NUM_PLAYERS-1:0]        en_q, en_d;
  logic [NUM_PLAYERS-1:0]        fin_q, fin_d;
  logic [NUM_PLAYERS-1:0]        fs_q, fs_d;
  logic [NUM_PLAYERS-1:0][11:0]  sec_q, sec_d;
  logic [NUM_PLAYERS-1:0][9:0]   ms_q, ms_d;
  logic [2:0]                    win_q, win_d;
  logic                          wv_q, wv_d;
  logic                          tie_q, tie_d;
  logic                          active_q, active_d;
  logic [NUM_PLAYERS-1:0]        new_fin;
  logic                          tick;

  assign tick = (div_q == DIV_END);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cd_ms_d = cd_ms_q;
    light_d = light_q;
    en_d    = en_q;
    fin_d   = fin_q;
    fs_d    = fs_q;
    sec_d   = sec_q;
    ms_d    = ms_q;
    win_d   = win_q;
    wv_d    = wv_q;
    tie_d   = tie_q;
    new_fin = '0;
    unique case (state_q)
      IDLE: begin
        if (start_game) state_d = COUNTDOWN;
      end
      COUNTDOWN: begin
        if (!start_game) begin
          state_d = IDLE;
          light_d = '0;
          cd_ms_d = '0;
          fs_d    = '0;
        end else begin
          fs_d = fs_q | throttle;
          if (light_q == LIGHT_END) begin
            state_d = RACE;
          end else if (tick) begin
            if (cd_ms_q == 10'd999) begin
              cd_ms_d = '0;
              light_d = light_q + 3'd1;
            end else begin
              cd_ms_d = cd_ms_q + 10'd1;
            end
          end
        end
      end
      RACE: begin
        // A finish freezes the timer, so a coincident tick is dropped
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (en_q[i]) begin
            if (position[i*POS_WIDTH +: POS_WIDTH] >= FINISH) begin
              fin_d[i] = 1'b1;
            end else if (tick) begin
              if (ms_q[i] != 10'd999) begin
                ms_d[i] = ms_q[i] + 10'd1;
              end else if (sec_q[i] != 12'hFFF) begin
                ms_d[i]  = '0;
                sec_d[i] = sec_q[i] + 12'd1;
              end
            end
          end
        end
        new_fin = fin_d & ~fin_q;
        if (!wv_q && (|new_fin)) begin
          wv_d  = 1'b1;
          tie_d = ($countones(new_fin) > 1);
          for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (new_fin[i]) win_d = 3'(i);
          end
        end
        if (&(fin_q | fs_q)) state_d = DONE;
        en_d = (state_d == RACE) ? (~fin_d & ~fs_q) : '0;
      end
      DONE: begin
      end
    endcase

    if (state_q == COUNTDOWN && state_d == RACE) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (fs_d[i]) begin
          sec_d[i] = '1;
          ms_d[i]  = '1;
        end
      end
    end

    if (state_d != state_q || state_q == IDLE || state_q == DONE) begin
      div_d = '0;
    end else begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    if (restart) begin
      state_d = IDLE;
      div_d   = '0;
      cd_ms_d = '0;
      light_d = '0;
      en_d    = '0;
      fin_d   = '0;
      fs_d    = '0;
      sec_d   = '0;
      ms_d    = '0;
      win_d   = '0;
      wv_d    = 1'b0;
      tie_d   = 1'b0;
    end
    active_d = (state_d == RACE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      cd_ms_q  <= '0;
      light_q  <= '0;
      en_q     <= '0;
      fin_q    <= '0;
      fs_q     <= '0;
      sec_q    <= '0;
      ms_q     <= '0;
      win_q    <= '0;
      wv_q     <= 1'b0;
      tie_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cd_ms_q  <= cd_ms_d;
      light_q  <= light_d;
      en_q     <= en_d;
      fin_q    <= fin_d;
      fs_q     <= fs_d;
      sec_q    <= sec_d;
      ms_q     <= ms_d;
      win_q    <= win_d;
      wv_q     <= wv_d;
      tie_q    <= tie_d;
      active_q <= active_d;
    end
  end

  assign state        = state_q;
  assign light_count  = light_q;
  assign race_active  = active_q;
  assign enable       = en_q;
  assign finished     = fin_q;
  assign false_start  = fs_q;
  assign winner       = win_q;
  assign winner_valid = wv_q;
  assign tie          = tie_q;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_rt
    assign race_time[g*22 +: 22] = {sec_q[g], ms_q[g]};
  end

endmodule
